// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: register-file geometry and ALU operation codes.
package cpu_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  // ALU operation select, as presented on the ALU sel input.
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MUL = 3'b010,
    ALU_DIV = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101
  } alu_sel_e;

endpackage

// File: rtl/status_reg.sv
// Registered ALU status flags (zero, overflow), captured when flag_we is high.
module status_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic flag_we,
  input  logic z_in,
  input  logic o_in,
  output logic z_q,
  output logic o_q
);

  // Capture both flags together on an enabled edge; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      o_q <= 1'b0;
    end else if (flag_we) begin
      z_q <= z_in;
      o_q <= o_in;
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with a hardwired-zero register and
// registered ALU status flags. Reads are combinational with no write bypass,
// so a read of the register being written returns the old value until the edge;
// this keeps the register-file -> ALU -> register-file path free of loops.
module register_file
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              z_in,
  input  logic              o_in,
  output logic              z_q,
  output logic              o_q
);

  localparam int                NUM_REGS  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_ok;

  // A write lands only when enabled and not aimed at the zero register.
  assign wr_ok = wr_en && (wr_addr != ZERO_ADDR);

  // Storage: async clear of every entry; the zero-register entry is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read ports; the zero register always reads as zero.
  always_comb begin
    rd_data1 = mem[rd_addr1];
    rd_data2 = mem[rd_addr2];
    if (rd_addr1 == ZERO_ADDR) rd_data1 = '0;
    if (rd_addr2 == ZERO_ADDR) rd_data2 = '0;
  end

  status_reg u_status_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flag_we (flag_we),
    .z_in    (z_in),
    .o_in    (o_in),
    .z_q     (z_q),
    .o_q     (o_q)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: an array model of the architectural
// registers and flags is compared with the DUT every mid-cycle, plus directed
// literal checks for the key scenarios.
module tb_register_file;
  import cpu_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int ZR = 31;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] rd_addr1 = '0;
  logic [AW-1:0] rd_addr2 = '0;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;
  logic          wr_en    = 1'b0;
  logic [AW-1:0] wr_addr  = '0;
  logic [DW-1:0] wr_data  = '0;
  logic          flag_we  = 1'b0;
  logic          z_in     = 1'b0;
  logic          o_in     = 1'b0;
  logic          z_q;
  logic          o_q;

  register_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .flag_we  (flag_we),
    .z_in     (z_in),
    .o_in     (o_in),
    .z_q      (z_q),
    .o_q      (o_q)
  );

  // ---------------- scoreboard counters ----------------
  int vectors    = 0;
  int miscompares = 0;
  bit started    = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Architectural view: 32 registers, zero register reads zero, writes land on
  // the edge, reset clears everything at once.
  logic [DW-1:0] m_regs [32];
  logic          m_z;
  logic          m_o;

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (int'(a) == ZR) return '0;
    return m_regs[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_z <= 1'b0;
      m_o <= 1'b0;
    end else begin
      if (wr_en && int'(wr_addr) != ZR) m_regs[wr_addr] <= wr_data;
      if (flag_we) begin
        m_z <= z_in;
        m_o <= o_in;
      end
    end
  end

  // Reference ALU for the loop-back scenario (only the ops the bench uses).
  function automatic logic [DW-1:0] alu_ref(input alu_sel_e sel, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (sel)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      default: return '0;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      check("rd_data1_model", rd_data1, m_read(rd_addr1));
      check("rd_data2_model", rd_data2, m_read(rd_addr2));
      check("z_q_model", {63'd0, z_q}, {63'd0, m_z});
      check("o_q_model", {63'd0, o_q}, {63'd0, m_o});
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after the rising edge, well clear of it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] a_v, b_v, res;

  initial begin
    step();
    step();
    rst_n   = 1'b1;
    started = 1'b1;
    step();
    check("reset_r0", rd_data1, 64'd0);

    // Fill every register with a distinct pattern, then sweep both ports.
    for (int i = 0; i < 32; i++) write_reg(AW'(i), {32'hA5A5_0000 | 32'(i), 32'(i) * 32'h0101_0101});
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = AW'(i);
      rd_addr2 = AW'(31 - i);
      step();
    end
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd30;
    #1;
    check("sweep_r0", rd_data1, 64'hA5A5_0000_0000_0000);
    check("sweep_r30", rd_data2, 64'hA5A5_001E_1E1E_1E1E);

    // Write then read with no bypass.
    write_reg(5'd3, 64'h55);
    rd_addr1 = 5'd3;
    wr_en    = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 64'h0123_4567_89AB_CDEF;
    #1;
    check("no_bypass_old", rd_data1, 64'h55);
    step();
    wr_en = 1'b0;
    check("write_new", rd_data1, 64'h0123_4567_89AB_CDEF);

    // Zero register discards writes.
    write_reg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_addr1 = 5'd31;
    rd_addr2 = 5'd31;
    #1;
    check("zero_p1", rd_data1, 64'd0);
    check("zero_p2", rd_data2, 64'd0);

    // Dual port.
    write_reg(5'd1, 64'd7);
    write_reg(5'd2, 64'd9);
    rd_addr1 = 5'd1;
    rd_addr2 = 5'd2;
    #1;
    check("dual_p1", rd_data1, 64'd7);
    check("dual_p2", rd_data2, 64'd9);
    rd_addr1 = 5'd2;
    #1;
    check("same_p1", rd_data1, 64'd9);
    check("same_p2", rd_data2, 64'd9);

    // Flags capture then hold.
    flag_we = 1'b1; z_in = 1'b1; o_in = 1'b0;
    step();
    flag_we = 1'b0; z_in = 1'b0; o_in = 1'b1;
    step();
    check("flag_z_hold", {63'd0, z_q}, 64'd1);
    check("flag_o_hold", {63'd0, o_q}, 64'd0);

    // Loop-back through the reference ALU: R4 = R1 - R2 with flags.
    write_reg(5'd1, 64'd5);
    write_reg(5'd2, 64'd3);
    rd_addr1 = 5'd1;
    rd_addr2 = 5'd2;
    #1;
    a_v = rd_data1;
    b_v = rd_data2;
    res = alu_ref(ALU_SUB, a_v, b_v);
    wr_en   = 1'b1;
    wr_addr = 5'd4;
    wr_data = res;
    flag_we = 1'b1;
    z_in    = (res == '0);
    o_in    = (a_v[DW-1] != b_v[DW-1]) && (res[DW-1] != a_v[DW-1]);
    step();
    wr_en = 1'b0; flag_we = 1'b0; o_in = 1'b0; z_in = 1'b0;
    rd_addr1 = 5'd4;
    #1;
    check("loop_r4", rd_data1, 64'd2);
    check("loop_z", {63'd0, z_q}, 64'd0);
    check("loop_o", {63'd0, o_q}, 64'd0);

    // Asynchronous reset mid-cycle.
    flag_we = 1'b1; z_in = 1'b1; o_in = 1'b1;
    write_reg(5'd5, 64'hDEAD);
    flag_we = 1'b0;
    rd_addr1 = 5'd5;
    #1;
    check("pre_reset_r5", rd_data1, 64'hDEAD);
    check("pre_reset_z", {63'd0, z_q}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_r5", rd_data1, 64'd0);
    check("async_z", {63'd0, z_q}, 64'd0);
    check("async_o", {63'd0, o_q}, 64'd0);

    // Writes and flag captures during reset are ignored.
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 64'h6666; flag_we = 1'b1; z_in = 1'b1; o_in = 1'b1;
    rd_addr2 = 5'd6;
    step();
    wr_en = 1'b0; flag_we = 1'b0;
    check("rst_write_r6", rd_data2, 64'd0);
    check("rst_flag_z", {63'd0, z_q}, 64'd0);

    // First write after release is accepted on the first edge.
    rst_n = 1'b1;
    write_reg(5'd7, 64'h77);
    rd_addr1 = 5'd7;
    #1;
    check("first_write_r7", rd_data1, 64'h77);
    check("post_rst_r6", rd_data2, 64'd0);

    step();
    step();
    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
